fc_controller: RTL and testbench

FC_CONTROLLER -- requirements
Module: fc_controller

---
 rtl/fc_controller_if.sv | 30 +++
 rtl/fc_controller.sv | 214 +++++++++++++++++++++
 tb/tb_fc_controller.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/fc_controller_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fc_controller_if : control and memory-port bundle for fc_controller
// Rev 1.0
// ---------------------------------------------------------------------------
interface fc_controller_if #(
  parameter int AW = 16
);
  logic          start;
  logic [AW-1:0] read_addr;
  logic [AW-1:0] write_addr;
  logic          busy;
  logic          finished;
  logic          mem_rd;
  logic          mem_wr;
  logic [AW-1:0] mem_addr;
  logic [15:0]   mem_wdata;
  logic [15:0]   mem_rdata;

  modport master (
    output start, read_addr, write_addr, mem_rdata,
    input  busy, finished, mem_rd, mem_wr, mem_addr, mem_wdata
  );

  modport slave (
    input  start, read_addr, write_addr, mem_rdata,
    output busy, finished, mem_rd, mem_wr, mem_addr, mem_wdata
  );
endinterface
`default_nettype wire

// File: rtl/fc_controller.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fc_controller : one fully-connected layer pass, Q8.8 MAC over a shared
//                 memory port. Macro FC_SATURATE_EN selects saturating output.
// Rev 1.0
// ---------------------------------------------------------------------------
module fc_controller #(
  parameter int NUM_IN  = 5,
  parameter int NUM_OUT = 3,
  parameter int AW      = 16
) (
  input  wire logic      clk,
  input  wire logic      rst,
  fc_controller_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD_IN = 3'd1,
    S_MAC     = 3'd2,
    S_BIAS    = 3'd3,
    S_WRITE   = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  localparam logic [7:0]    c_NI      = 8'(NUM_IN);
  localparam logic [7:0]    c_NO_LAST = 8'(NUM_OUT - 1);
  localparam logic [AW-1:0] c_WOFF    = AW'(NUM_IN);
  localparam logic [AW-1:0] c_BOFF    = AW'(NUM_IN + NUM_IN * NUM_OUT);

  state_t             r_state, w_state_nxt;
  logic [7:0]         r_cnt, w_cnt_nxt;
  logic [7:0]         r_j, w_j_nxt;
  logic [AW-1:0]      r_rbase, w_rbase_nxt;
  logic [AW-1:0]      r_wbase, w_wbase_nxt;
  logic [AW-1:0]      r_wptr, w_wptr_nxt;
  logic signed [31:0] r_acc, w_acc_nxt;
  logic signed [15:0] r_in [NUM_IN];
  logic               w_in_shift;
  logic signed [15:0] w_in_new;
  logic               r_busy, w_busy_nxt;
  logic               r_fin, w_fin_nxt;
  logic               r_rd, w_rd_nxt;
  logic               r_wr, w_wr_nxt;
  logic [AW-1:0]      r_addr, w_addr_nxt;
  logic [15:0]        r_wdata, w_wdata_nxt;
  logic signed [31:0] w_rdata_sx, w_in_sx, w_prod;
  logic [15:0]        w_conv;

  assign w_rdata_sx = {{16{bus.mem_rdata[15]}}, bus.mem_rdata};
  assign w_in_sx    = {{16{r_in[0][15]}}, r_in[0]};
  assign w_prod     = (w_rdata_sx * w_in_sx) >>> 8;

`ifdef FC_SATURATE_EN
  assign w_conv = (w_acc_nxt > 32'sd32767)  ? 16'h7FFF :
                  (w_acc_nxt < -32'sd32768) ? 16'h8000 : w_acc_nxt[15:0];
`else
  assign w_conv = w_acc_nxt[15:0];
`endif

  // Outputs are registered from the next-state view so each strobe lines up
  // with the state that owns it; the input file rotates so r_in[0] is always
  // the operand paired with the weight returning this cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_j_nxt     = r_j;
    w_rbase_nxt = r_rbase;
    w_wbase_nxt = r_wbase;
    w_wptr_nxt  = r_wptr;
    w_acc_nxt   = r_acc;
    w_in_shift  = 1'b0;
    w_in_new    = r_in[0];
    w_rd_nxt    = 1'b0;
    w_wr_nxt    = 1'b0;
    w_fin_nxt   = 1'b0;
    w_addr_nxt  = r_addr;

    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_state_nxt = S_LOAD_IN;
          w_cnt_nxt   = 8'd0;
          w_j_nxt     = 8'd0;
          w_rbase_nxt = bus.read_addr;
          w_wbase_nxt = bus.write_addr;
        end
      end
      S_LOAD_IN: begin
        if (r_cnt != 8'd0) begin
          w_in_shift = 1'b1;
          w_in_new   = bus.mem_rdata;
        end
        if (r_cnt == c_NI) begin
          w_state_nxt = S_MAC;
          w_cnt_nxt   = 8'd0;
          w_acc_nxt   = '0;
          w_wptr_nxt  = c_WOFF;
        end else begin
          w_cnt_nxt = r_cnt + 8'd1;
        end
      end
      S_MAC: begin
        if (r_cnt != 8'd0) begin
          w_in_shift = 1'b1;
          w_acc_nxt  = r_acc + w_prod;
        end
        if (r_cnt == c_NI) begin
          w_state_nxt = S_BIAS;
          w_cnt_nxt   = 8'd0;
        end else begin
          w_cnt_nxt  = r_cnt + 8'd1;
          w_wptr_nxt = r_wptr + AW'(1);
        end
      end
      S_BIAS: begin
        if (r_cnt == 8'd0) begin
          w_cnt_nxt = 8'd1;
        end else begin
          w_acc_nxt   = r_acc + w_rdata_sx;
          w_state_nxt = S_WRITE;
        end
      end
      S_WRITE: begin
        if (r_j == c_NO_LAST) begin
          w_state_nxt = S_DONE;
        end else begin
          w_j_nxt     = r_j + 8'd1;
          w_state_nxt = S_MAC;
          w_cnt_nxt   = 8'd0;
          w_acc_nxt   = '0;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase

    case (w_state_nxt)
      S_LOAD_IN: begin
        if (w_cnt_nxt != c_NI) begin
          w_rd_nxt   = 1'b1;
          w_addr_nxt = w_rbase_nxt + AW'(w_cnt_nxt);
        end
      end
      S_MAC: begin
        if (w_cnt_nxt != c_NI) begin
          w_rd_nxt   = 1'b1;
          w_addr_nxt = w_rbase_nxt + w_wptr_nxt;
        end
      end
      S_BIAS: begin
        if (w_cnt_nxt == 8'd0) begin
          w_rd_nxt   = 1'b1;
          w_addr_nxt = w_rbase_nxt + c_BOFF + AW'(w_j_nxt);
        end
      end
      S_WRITE: begin
        w_wr_nxt   = 1'b1;
        w_addr_nxt = w_wbase_nxt + AW'(w_j_nxt);
      end
      S_DONE:  w_fin_nxt = 1'b1;
      default: ;
    endcase

    w_busy_nxt  = (w_state_nxt != S_IDLE);
    w_wdata_nxt = (w_state_nxt == S_WRITE) ? w_conv : r_wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_j     <= '0;
      r_rbase <= '0;
      r_wbase <= '0;
      r_wptr  <= '0;
      r_acc   <= '0;
      r_busy  <= 1'b0;
      r_fin   <= 1'b0;
      r_rd    <= 1'b0;
      r_wr    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      for (int k = 0; k < NUM_IN; k++) r_in[k] <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_j     <= w_j_nxt;
      r_rbase <= w_rbase_nxt;
      r_wbase <= w_wbase_nxt;
      r_wptr  <= w_wptr_nxt;
      r_acc   <= w_acc_nxt;
      r_busy  <= w_busy_nxt;
      r_fin   <= w_fin_nxt;
      r_rd    <= w_rd_nxt;
      r_wr    <= w_wr_nxt;
      r_addr  <= w_addr_nxt;
      r_wdata <= w_wdata_nxt;
      if (w_in_shift) begin
        for (int k = 0; k < NUM_IN - 1; k++) r_in[k] <= r_in[k+1];
        r_in[NUM_IN-1] <= w_in_new;
      end
    end
  end

  assign bus.busy      = r_busy;
  assign bus.finished  = r_fin;
  assign bus.mem_rd    = r_rd;
  assign bus.mem_wr    = r_wr;
  assign bus.mem_addr  = r_addr;
  assign bus.mem_wdata = r_wdata;

endmodule
`default_nettype wire

// File: tb/tb_fc_controller.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_fc_controller : scoreboard bench for fc_controller (NUM_IN=5, NUM_OUT=3)
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_fc_controller;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;

  logic [15:0] mem [0:65535];
  logic [15:0] q_rd  [$];
  logic [31:0] q_wr  [$];
  int          q_fin [$];
  logic        r_pend = 1'b0;
  logic [15:0] r_pend_addr = 16'h0;

`ifdef FC_SATURATE_EN
  localparam logic [15:0] c_EXP_BIG = 16'h7FFF;
  localparam logic [15:0] c_EXP_NEG = 16'h8000;
`else
  localparam logic [15:0] c_EXP_BIG = 16'h0500;
  localparam logic [15:0] c_EXP_NEG = 16'hFB00;
`endif

  fc_controller_if #(.AW(16)) bus ();

  fc_controller #(.NUM_IN(5), .NUM_OUT(3), .AW(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic unexpected(input string name, input logic [31:0] act);
    n_vec++;
    n_err++;
    $display("FAIL %s: got event with value %h, want none (cycle %0d)", name, act, cyc);
  endtask

  // Memory model: data for a read strobe is presented during the next cycle.
  always @(negedge clk) begin
    bus.mem_rdata = r_pend ? mem[r_pend_addr] : 16'hDEAD;
    r_pend        = bus.mem_rd;
    r_pend_addr   = bus.mem_addr;
  end

  // Monitor: pops the scoreboard whenever the DUT strobes.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.mem_rd || bus.mem_wr)
        chk("strobe_excl", 32'(bus.mem_rd & bus.mem_wr), 32'd0);
      if (bus.mem_rd) begin
        if (q_rd.size() == 0) unexpected("rd_unexpected", 32'(bus.mem_addr));
        else chk("rd_addr", 32'(bus.mem_addr), 32'(q_rd.pop_front()));
      end
      if (bus.mem_wr) begin
        if (q_wr.size() == 0) unexpected("wr_unexpected", {bus.mem_addr, bus.mem_wdata});
        else chk("wr_addr_data", {bus.mem_addr, bus.mem_wdata}, q_wr.pop_front());
      end
      if (bus.finished) begin
        if (q_fin.size() == 0) unexpected("fin_unexpected", 32'(cyc));
        else begin
          chk("fin_cycle", 32'(cyc), 32'(q_fin.pop_front()));
          chk("busy_in_done", 32'(bus.busy), 32'd1);
        end
      end
    end
  end

  task automatic chk_reset_outputs();
    chk("rst_busy",  32'(bus.busy),      32'd0);
    chk("rst_fin",   32'(bus.finished),  32'd0);
    chk("rst_rd",    32'(bus.mem_rd),    32'd0);
    chk("rst_wr",    32'(bus.mem_wr),    32'd0);
    chk("rst_addr",  32'(bus.mem_addr),  32'd0);
    chk("rst_wdata", 32'(bus.mem_wdata), 32'd0);
  endtask

  task automatic fill(input logic [15:0] rb, input logic [15:0] inv, input logic [15:0] wv,
                      input logic [15:0] b0, input logic [15:0] b1, input logic [15:0] b2);
    for (int i = 0; i < 5; i++)  mem[16'(rb + 16'(i))] = inv;
    for (int k = 0; k < 15; k++) mem[16'(rb + 16'(5 + k))] = wv;
    mem[16'(rb + 16'd20)] = b0;
    mem[16'(rb + 16'd21)] = b1;
    mem[16'(rb + 16'd22)] = b2;
  endtask

  // rp: re-pulse start at cycles 3, 20 and 34 (DONE); rst_at: cycle to reset (0 = never)
  task automatic run_pass(input logic [15:0] rb, input logic [15:0] wb,
                          input logic [15:0] e0, input logic [15:0] e1, input logic [15:0] e2,
                          input bit rp, input int rst_at);
    logic [15:0] e [3];
    int s;
    e[0] = e0; e[1] = e1; e[2] = e2;
    for (int i = 0; i < 5; i++) q_rd.push_back(16'(rb + 16'(i)));
    for (int j = 0; j < 3; j++) begin
      for (int i = 0; i < 5; i++) q_rd.push_back(16'(rb + 16'(5 + j * 5 + i)));
      q_rd.push_back(16'(rb + 16'(20 + j)));
      q_wr.push_back({16'(wb + 16'(j)), e[j]});
    end
    @(negedge clk);
    bus.read_addr  = rb;
    bus.write_addr = wb;
    bus.start      = 1'b1;
    s = cyc;
    q_fin.push_back(s + 34);
    @(negedge clk);
    bus.start      = 1'b0;
    bus.read_addr  = 16'hBEEF;
    bus.write_addr = 16'h5A5A;
    for (int k = 2; k <= 40; k++) begin
      @(negedge clk);
      bus.start = rp && (k == 3 || k == 20 || k == 34);
      if (k == rst_at) begin
        #2 rst = 1'b1;
        #1 chk_reset_outputs();
        q_rd.delete();
        q_wr.delete();
        q_fin.delete();
        @(negedge clk);
        #2 rst = 1'b0;
      end
    end
    chk("fin_pending", 32'(q_fin.size()), 32'd0);
    chk("wr_pending",  32'(q_wr.size()),  32'd0);
    chk("rd_pending",  32'(q_rd.size()),  32'd0);
    chk("busy_idle",   32'(bus.busy),     32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.start      = 1'b0;
    bus.read_addr  = 16'h0;
    bus.write_addr = 16'h0;
    repeat (3) @(negedge clk);
    chk_reset_outputs();
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Unit inputs and weights, zero bias
    fill(16'h0100, 16'h0100, 16'h0100, 16'h0000, 16'h0000, 16'h0000);
    run_pass(16'h0100, 16'h0800, 16'h0500, 16'h0500, 16'h0500, 1'b0, 0);

    // Mixed-sign biases
    fill(16'h0200, 16'h0100, 16'h0100, 16'h0080, 16'hFF00, 16'h0000);
    run_pass(16'h0200, 16'h0900, 16'h0580, 16'h0400, 16'h0500, 1'b0, 0);

    // Large positive products
    fill(16'h0400, 16'h7F00, 16'h7F00, 16'h0000, 16'h0000, 16'h0000);
    run_pass(16'h0400, 16'h0A00, c_EXP_BIG, c_EXP_BIG, c_EXP_BIG, 1'b0, 0);

    // Large negative products
    fill(16'h0500, 16'h8100, 16'h7F00, 16'h0000, 16'h0000, 16'h0000);
    run_pass(16'h0500, 16'h0B00, c_EXP_NEG, c_EXP_NEG, c_EXP_NEG, 1'b0, 0);

    // Distinct weights exercise input/weight pairing: 1.0, 2.5, -1.0
    fill(16'h0300, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
    for (int i = 0; i < 5; i++) mem[16'(16'h0300 + 16'(i))] = 16'((i + 1) * 256);
    mem[16'h0300 + 16'd5]  = 16'h0100;
    mem[16'h0300 + 16'd14] = 16'h0080;
    mem[16'h0300 + 16'd16] = 16'hFF00;
    mem[16'h0300 + 16'd18] = 16'h0040;
    run_pass(16'h0300, 16'h0C00, 16'h0100, 16'h0280, 16'hFF00, 1'b0, 0);

    // Start re-pulsed mid-pass and during DONE must be ignored
    run_pass(16'h0100, 16'h0D00, 16'h0500, 16'h0500, 16'h0500, 1'b1, 0);

    // Reset mid-pass aborts; the next pass completes normally
    run_pass(16'h0200, 16'h0E00, 16'h0580, 16'h0400, 16'h0500, 1'b0, 15);
    run_pass(16'h0200, 16'h0F00, 16'h0580, 16'h0400, 16'h0500, 1'b0, 0);

    repeat (5) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
